// File: rtl/fpu_issue_sequencer.sv
// Issue/completion sequencer for the multi-cycle FPU: accepts one FP op, times its
// latency, holds the result for writeback, and raises structural and RAW pipeline stalls.
module fpu_issue_sequencer #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ADD_LAT = 3,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [1:0]        issue_op,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  input  logic              kill,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  output logic              fpu_start,
  output logic [1:0]        fpu_op,
  output logic [DATA_W-1:0] fpu_a,
  output logic [DATA_W-1:0] fpu_b,
  input  logic [DATA_W-1:0] fpu_result,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ack,
  output logic              pipe_stall,
  output logic              busy,
  output logic [1:0]        dbgState
);

  localparam int MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               pendValid;
  logic               killed;
  logic [REG_W-1:0]   pendRd;
  logic               rawHit;

  function automatic logic [CNT_W-1:0] latOf(input logic [1:0] op);
    case (op)
      2'd2:    return CNT_W'(MUL_LAT);
      2'd3:    return CNT_W'(DIV_LAT);
      default: return CNT_W'(ADD_LAT);
    endcase
  endfunction

  // Handshakes: an issue transfers on a clock edge where issue_valid && issue_ready && !kill;
  // a result transfers on an edge where wb_valid && wb_ack. wb_ack without wb_valid is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pendValid <= 1'b0;
      killed    <= 1'b0;
      pendRd    <= '0;
      fpu_start <= 1'b0;
      fpu_op    <= '0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      fpu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_valid && !kill) begin
            state     <= EXEC;
            fpu_start <= 1'b1;
            fpu_op    <= issue_op;
            fpu_a     <= issue_a;
            fpu_b     <= issue_b;
            pendRd    <= issue_rd;
            pendValid <= 1'b1;
            killed    <= 1'b0;
            cnt       <= latOf(issue_op);
          end
        end
        EXEC: begin
          cnt <= cnt - CNT_W'(1);
          // A kill cannot abort the FPU, so the count always runs out; it only suppresses writeback.
          if (kill) begin
            killed    <= 1'b1;
            pendValid <= 1'b0;
          end
          if (cnt == CNT_W'(1)) begin
            wb_data <= fpu_result;
            wb_rd   <= pendRd;
            if (killed || kill) begin
              state     <= IDLE;
              pendValid <= 1'b0;
            end else begin
              state    <= WB;
              wb_valid <= 1'b1;
            end
          end
        end
        WB: begin
          if (wb_ack || kill) begin
            wb_valid  <= 1'b0;
            pendValid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rawHit      = pendValid && ((id_use_rs && (id_rs == pendRd)) ||
                                (id_use_rt && (id_rt == pendRd)));
    issue_ready = (state == IDLE);
    busy        = (state != IDLE);
    pipe_stall  = !kill && ((issue_valid && (state != IDLE)) || rawHit);
    dbgState    = state;
  end

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Directed bench for fpu_issue_sequencer: a timestamp-based transaction model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_fpu_issue_sequencer;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ADD_LAT = 3;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 12;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              issue_valid = 1'b0;
  logic              issue_ready;
  logic [1:0]        issue_op = '0;
  logic [REG_W-1:0]  issue_rd = '0;
  logic [DATA_W-1:0] issue_a = '0;
  logic [DATA_W-1:0] issue_b = '0;
  logic              kill = 1'b0;
  logic [REG_W-1:0]  id_rs = '0;
  logic [REG_W-1:0]  id_rt = '0;
  logic              id_use_rs = 1'b0;
  logic              id_use_rt = 1'b0;
  logic              fpu_start;
  logic [1:0]        fpu_op;
  logic [DATA_W-1:0] fpu_a;
  logic [DATA_W-1:0] fpu_b;
  logic [DATA_W-1:0] fpu_result;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ack = 1'b0;
  logic              pipe_stall;
  logic              busy;
  logic [1:0]        dbgState;

  fpu_issue_sequencer #(
    .DATA_W(DATA_W), .REG_W(REG_W), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_rd(issue_rd), .issue_a(issue_a), .issue_b(issue_b), .kill(kill),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_result(fpu_result), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_ack(wb_ack), .pipe_stall(pipe_stall), .busy(busy), .dbgState(dbgState)
  );

  // Stand-in FPU: 1.0 + 2.0 = 3.0 for the add scenario, otherwise an operand-dependent hash.
  function automatic logic [31:0] fakeFpu(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    if (op == 2'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a ^ {b[15:0], b[31:16]}) + {30'd0, op};
  endfunction

  assign fpu_result = fakeFpu(fpu_op, fpu_a, fpu_b);

  function automatic int latOf(input logic [1:0] op);
    if (op == 2'd2) return MUL_LAT;
    if (op == 2'd3) return DIV_LAT;
    return ADD_LAT;
  endfunction

  // ---------------- scoreboard counters ----------------
  int nVec = 0;
  int nMis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // One in-flight op described by its accept edge and the edge its latency expires.
  int               edgeN;
  int               mAccept;
  int               mDone;
  logic             mBusy, mInWb, mPend, mKilled;
  logic [1:0]       mOp;
  logic [REG_W-1:0] mRd;
  logic [31:0]      mA, mB;
  logic [REG_W-1:0] mWbRd;
  logic [31:0]      mWbData;
  logic [31:0]      expQ[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edgeN <= 0; mAccept <= -10; mDone <= -10;
      mBusy <= 1'b0; mInWb <= 1'b0; mPend <= 1'b0; mKilled <= 1'b0;
      mOp <= '0; mRd <= '0; mA <= '0; mB <= '0; mWbRd <= '0; mWbData <= '0;
    end else begin
      edgeN <= edgeN + 1;
      if (!mBusy) begin
        if (issue_valid && !kill) begin
          mBusy <= 1'b1; mInWb <= 1'b0; mPend <= 1'b1; mKilled <= 1'b0;
          mOp <= issue_op; mRd <= issue_rd; mA <= issue_a; mB <= issue_b;
          mAccept <= edgeN + 1;
          mDone   <= edgeN + 1 + latOf(issue_op);
        end
      end else if (!mInWb) begin
        if (kill) begin mKilled <= 1'b1; mPend <= 1'b0; end
        if (edgeN + 1 == mDone) begin
          mWbRd   <= mRd;
          mWbData <= fakeFpu(mOp, mA, mB);
          if (mKilled || kill) begin mBusy <= 1'b0; mPend <= 1'b0; end
          else mInWb <= 1'b1;
        end
      end else if (wb_ack || kill) begin
        if (wb_ack) expQ.push_back(mWbData);
        mBusy <= 1'b0; mInWb <= 1'b0; mPend <= 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("issue_ready", issue_ready, !mBusy);
    check("busy",        busy,        mBusy);
    check("dbg_busy",    dbgState != 2'd0, mBusy);
    check("fpu_start",   fpu_start,   mBusy && !mInWb && (edgeN == mAccept));
    check("fpu_op",      fpu_op,      mOp);
    check("fpu_a",       fpu_a,       mA);
    check("fpu_b",       fpu_b,       mB);
    check("wb_valid",    wb_valid,    mInWb);
    check("wb_rd",       wb_rd,       mWbRd);
    check("wb_data",     wb_data,     mWbData);
    check("pipe_stall",  pipe_stall,
          !kill && ((issue_valid && mBusy) ||
                    (mPend && ((id_use_rs && id_rs == mRd) || (id_use_rt && id_rt == mRd)))));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [REG_W-1:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    issue_valid = 1'b1; issue_op = op; issue_rd = rd; issue_a = a; issue_b = b;
  endtask

  // Steps until wb_valid; n continues counting cycles from the accept cycle.
  task automatic runToWb(input int start, output int n);
    n = start;
    while (!wb_valid && n < 40) begin
      step();
      n++;
    end
    if (!wb_valid) check("wb_timeout", 32'd0, 32'd1);
  endtask

  task automatic ackWb();
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
  endtask

  int n;
  int nAcks;

  initial begin
    nAcks = 0;
    // ---- reset ----
    repeat (2) step();
    check("rst_issue_ready", issue_ready, 1);
    check("rst_busy",        busy,        0);
    check("rst_wb_valid",    wb_valid,    0);
    check("rst_wb_data",     wb_data,     0);
    rst_n = 1'b1;
    step();

    // ---- add 1.0 + 2.0 -> rd 4 ----
    issue(2'd0, 5'd4, 32'h3F80_0000, 32'h4000_0000);
    step();
    issue_valid = 1'b0;
    check("add_start",  fpu_start, 1);
    check("add_busy",   busy, 1);
    check("add_ready",  issue_ready, 0);
    step();
    check("add_start_once", fpu_start, 0);
    runToWb(2, n);
    check("add_latency", n, 4);
    check("add_wb_rd",   wb_rd, 4);
    check("add_wb_data", wb_data, 32'h4040_0000);
    check("model_add_data", mWbData, 32'h4040_0000);
    repeat (2) begin
      step();
      check("add_wb_hold", wb_valid, 1);
    end
    ackWb(); nAcks++;
    check("add_wb_drop", wb_valid, 0);
    check("add_idle",    busy, 0);

    // ---- div with a second FP op held behind it ----
    issue(2'd3, 5'd9, 32'h1234_5678, 32'h0F0F_A5A5);
    step();
    issue(2'd0, 5'd10, 32'hCAFE_0001, 32'h0000_BEEF);
    check("div_stall", pipe_stall, 1);
    check("div_ready", issue_ready, 0);
    runToWb(1, n);
    check("div_latency", n, DIV_LAT + 1);
    check("div_wb_rd",   wb_rd, 9);
    check("div_wb_stall", pipe_stall, 1);
    ackWb(); nAcks++;
    check("div_after_ack_ready", issue_ready, 1);
    check("div_after_ack_stall", pipe_stall, 0);
    step();
    issue_valid = 1'b0;
    check("second_start", fpu_start, 1);
    check("second_op",    fpu_op, 0);
    runToWb(1, n);
    check("second_latency", n, ADD_LAT + 1);
    check("second_wb_rd",   wb_rd, 10);
    ackWb(); nAcks++;

    // ---- mul rd 7 with RAW on id_rt ----
    id_rt = 5'd7; id_use_rt = 1'b1;
    issue(2'd2, 5'd7, 32'h4040_0000, 32'h4080_0000);
    step();
    issue_valid = 1'b0;
    check("mul_raw_stall", pipe_stall, 1);
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    check("mul_stray_ack_busy", busy, 1);
    id_use_rt = 1'b0;
    #1;
    check("mul_rt_unused", pipe_stall, 0);
    id_use_rt = 1'b1;
    runToWb(2, n);
    check("mul_latency", n, MUL_LAT + 1);
    check("mul_wb_stall", pipe_stall, 1);
    ackWb(); nAcks++;
    check("mul_stall_clear", pipe_stall, 0);
    id_use_rt = 1'b0;

    // ---- kill on cycle 2 of a mul ----
    id_rs = 5'd7; id_use_rs = 1'b1;
    issue(2'd2, 5'd7, 32'h0000_0003, 32'h0000_0005);
    step();
    issue_valid = 1'b0;
    check("kill_pre_stall", pipe_stall, 1);
    step();
    kill = 1'b1;
    #1;
    check("kill_masks_stall", pipe_stall, 0);
    step();
    kill = 1'b0;
    check("kill_raw_gone", pipe_stall, 0);
    check("kill_busy3",    busy, 1);
    step();
    check("kill_busy4",    busy, 1);
    step();
    check("kill_done_idle", busy, 0);
    check("kill_no_wb",     wb_valid, 0);
    id_use_rs = 1'b0;

    // ---- kill with issue_valid in IDLE ----
    kill = 1'b1;
    issue(2'd0, 5'd1, 32'h1, 32'h2);
    step();
    issue_valid = 1'b0; kill = 1'b0;
    check("idle_kill_busy",  busy, 0);
    check("idle_kill_start", fpu_start, 0);

    // ---- kill in WB without ack ----
    issue(2'd1, 5'd0, 32'h0000_00AA, 32'h0000_0055);
    step();
    issue_valid = 1'b0;
    runToWb(1, n);
    check("sub_latency", n, ADD_LAT + 1);
    kill = 1'b1;
    step();
    kill = 1'b0;
    check("wbkill_drop", wb_valid, 0);
    check("wbkill_idle", busy, 0);

    // ---- kill together with wb_ack ----
    issue(2'd0, 5'd3, 32'h0000_1111, 32'h0000_2222);
    step();
    issue_valid = 1'b0;
    runToWb(1, n);
    kill = 1'b1;
    ackWb(); nAcks++;
    kill = 1'b0;
    check("killack_idle", busy, 0);
    check("killack_drop", wb_valid, 0);
    check("killack_counted", expQ.size(), nAcks);

    // ---- async reset during div ----
    issue(2'd3, 5'd12, 32'h7777_0000, 32'h0000_8888);
    step();
    issue_valid = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",  busy, 0);
    check("arst_ready", issue_ready, 1);
    check("arst_start", fpu_start, 0);
    check("arst_fpu_a", fpu_a, 0);
    check("arst_wb",    wb_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    issue(2'd0, 5'd4, 32'h3F80_0000, 32'h4000_0000);
    step();
    issue_valid = 1'b0;
    runToWb(1, n);
    check("post_rst_latency", n, ADD_LAT + 1);
    check("post_rst_data",    wb_data, 32'h4040_0000);
    ackWb();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
